// File: rtl/gcd_arbiter_pkg.sv
// Shared constants and FSM state type for the GCD engine arbiter.
// The optional watchdog is enabled by defining GCD_ARB_TIMEOUT_EN.
package gcd_arb_pkg;

  localparam int N_REQ_DEF          = 4;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1023;

  localparam int IDLE_BIT = 0;
  localparam int LOAD_BIT = 1;
  localparam int WAIT_BIT = 2;
  localparam int RESP_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001 << IDLE_BIT,
    ST_LOAD = 4'b0001 << LOAD_BIT,
    ST_WAIT = 4'b0001 << WAIT_BIT,
    ST_RESP = 4'b0001 << RESP_BIT
  } state_t;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side bundle of the GCD arbiter: request and response handshakes.
// rsp_err exists only when GCD_ARB_TIMEOUT_EN is defined.
interface gcd_arbiter_if
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
`ifdef GCD_ARB_TIMEOUT_EN
  logic                    rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
`else
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
`endif

endinterface

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
// Reusable by any arbiter sharing one datapath among N requesters.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id
);

  logic [ID_W-1:0] idx;
  logic            found;

  // NOTE: every output gets a default before the loop so this block never infers a latch.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((32'(ptr) + 32'(k)) % 32'(N));
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one external GCD engine among N_REQ requesters.
// Define GCD_ARB_TIMEOUT_EN to add the WAIT watchdog and the rsp_err flag.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  gcd_arbiter_if.slave      bus,
  output logic              eng_rst,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  input  logic [DATA_W-1:0] eng_ret,
  input  logic              eng_done
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]  pick_oh;
  logic [ID_W-1:0]   pick_id;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;

  assign bus.rsp_err = rsp_err_q;
`endif

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .id    (pick_id)
  );

  // Gated by rst so a request seen while in reset is never acknowledged.
  assign bus.req_ready = (state[IDLE_BIT] && !rst) ? pick_oh : '0;
  assign eng_rst       = rst | state[LOAD_BIT];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt_id      <= '0;
      rr_ptr      <= ID_W'(N_REQ - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      eng_a       <= '0;
      eng_b       <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick_oh) begin
            eng_a  <= bus.req_a[pick_id*DATA_W +: DATA_W];
            eng_b  <= bus.req_b[pick_id*DATA_W +: DATA_W];
            gnt_id <= pick_id;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
`ifdef GCD_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            rsp_data_q  <= eng_ret;
            rsp_valid_q <= N_REQ'(1) << gnt_id;
            state       <= ST_RESP;
          end
`ifdef GCD_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= N_REQ'(1) << gnt_id;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          // Only the granted requester's rsp_ready completes the handshake.
          if (bus.rsp_ready[gnt_id]) begin
            rsp_valid_q <= '0;
            rr_ptr      <= gnt_id;
`ifdef GCD_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Shares one 8-bit GCD engine among N_REQ requesters, with round-robin arbitration and per-requester valid/ready handshakes.
- Owns the engine's load/reset pin and sequences it through load → wait-for-done → respond.
- Routes the result back to the requester that was granted.
- Sits between the GCD engine and client blocks; the engine is instantiated beside it in the parent, not inside.
- Engine contract (fixed): engine captures a_in/b_in on every clock edge where its reset input is high. It later raises done_out with ret_out valid, and holds both until its next reset.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width; must match engine width.
- TIMEOUT_CYCLES, 1023, watchdog limit in cycles; used only with GCD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, on clk.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  N_REQ*DATA_W  operand a; requester i uses slice [i*DATA_W +: DATA_W].
- req_b  in  N_REQ*DATA_W  operand b; same slicing.
- rsp_valid  out  N_REQ  per-requester response valid; at most one bit high.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_data  out  DATA_W  result, shared bus; qualified by rsp_valid.
- rsp_err  out  1  timeout flag; present only with GCD_ARB_TIMEOUT_EN.
- eng_rst  out  1  engine reset/load = rst OR (state==LOAD).
- eng_a  out  DATA_W  latched operand a.
- eng_b  out  DATA_W  latched operand b.
- eng_ret  in  DATA_W  engine result.
- eng_done  in  1  engine done.

Behaviour:
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; eng_a=0; eng_b=0; grant id=0; rr pointer=N_REQ-1, so requester 0 wins first; rsp_err=0.
- State encoding: one-hot, four states.
- IDLE:
  - req_ready is driven combinationally, only in IDLE.
  - If any req_valid: pick the first set bit searching upward from (pointer+1) mod N_REQ, with wrap.
  - Assert req_ready for that requester for one cycle.
  - On that edge, latch req_a/req_b slices into eng_a/eng_b, store the id, go to LOAD.
- LOAD: eng_rst=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - eng_done is ignored in the LOAD cycle; the engine clears done during its reset.
  - When eng_done=1: capture eng_ret into rsp_data, go to RESP.
- RESP:
  - rsp_valid[id]=1 and rsp_data held stable until rsp_ready[id]=1.
  - On handshake: pointer←id, go to IDLE.
  - Earliest next grant is the following cycle.
- Latency: rsp_valid rises exactly 1 cycle after the first cycle eng_done is high in WAIT. Accept → engine reset is 1 cycle.
- Throughput: one operation in flight; a new grant happens only from IDLE.
- req_valid deasserted by an un-granted requester: legal; it is simply not considered.
- A granted requester that holds req_valid high after acceptance gets a second, separate operation later.
- Operand boundaries are passed through untouched:
  - b=0 → result a.
  - a=0, b=0 → result 0.
- rst mid-operation:
  - Any state → IDLE next cycle; engine reset via OR path.
  - Pending response is discarded, no rsp_valid; pointer is reset.
- rsp_ready of non-granted requesters is ignored.

Optional Feature:
- Macro: GCD_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without eng_done: go to RESP with rsp_data=0 and rsp_err=1.
  - rsp_err clears on the response handshake.
  - The engine is re-reset on the next LOAD as normal.
- Without the macro: no counter, no rsp_err port; WAIT waits indefinitely.

Decomposition:
- Package gcd_arb_pkg holds:
  - state localparams (IDLE/LOAD/WAIT/RESP one-hot values and bit indices);
  - default DATA_W and N_REQ;
  - the TIMEOUT_CYCLES default.
- One sub-module, rr_pick: purely combinational.
  - Inputs: N_REQ request vector and pointer.
  - Outputs: one-hot grant and binary id.
  - Reusable by other shared-datapath arbiters.

Test Plan:
- Single request from req 2 with a=48, b=18:
  - req_ready[2] pulses 1 cycle; eng_rst high 1 cycle with eng_a=48, eng_b=18;
  - later rsp_valid[2]=1 with rsp_data=6.
- Boundary operands, in order: (17,0) → 17; (0,5) → 5; (0,0) → 0; (255,255) → 255.
- All 4 requesters valid continuously after reset:
  - grant order 0,1,2,3,0,1;
  - never two bits set in req_ready or rsp_valid.
- Backpressure: rsp_ready[1] low for 10 cycles in RESP:
  - rsp_valid[1] and rsp_data held constant;
  - no new grant until the handshake.
- rst pulsed 1 cycle during WAIT of req 3:
  - no rsp_valid for that op; state returns to IDLE;
  - the next request from req 3 is re-served correctly.
- With GCD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine stub holding eng_done=0:
  - rsp_valid with rsp_err=1, rsp_data=0 after 16 WAIT cycles;
  - the next op with a real engine returns rsp_err=0.
